// File: rtl/instr_fetch_seq_pkg.sv
// fetch_pkg: shared types and widths for the instruction fetch sequencer.
//   state_t          : fetch FSM states (IDLE, FH, FHC, FL, FLC, EXEC, HALT)
//   ROM_DATA_W       : ROM byte width
//   INSTR_W          : assembled instruction width
//   OPCODE_W         : opcode field width
//   HALT_OP_DEFAULT  : opcode that stops fetching
package fetch_pkg;
    localparam int ROM_DATA_W = 8;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_W   = 4;
    localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 4'hF;
    typedef enum logic [2:0] {IDLE, FH, FHC, FL, FLC, EXEC, HALT} state_t;
endpackage

// File: rtl/instr_fetch_seq_if.sv
// instr_fetch_seq_if: bus bundle between the fetch sequencer and its environment.
//   master (fetch side): drives rom_rd/rom_addr, opcode/operand/ir_valid, pc_out,
//                        halted, fetch_busy; receives start, rom_data, exec_done,
//                        jmp_en, jmp_addr.
//   slave (ROM/control/datapath side): the reverse.
interface instr_fetch_seq_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic                          start;
    logic                          rom_rd;
    logic [ADDR_W-1:0]             rom_addr;
    logic [ROM_DATA_W-1:0]         rom_data;
    logic [OPCODE_W-1:0]           opcode;
    logic [INSTR_W-OPCODE_W-1:0]   operand;
    logic                          ir_valid;
    logic                          exec_done;
    logic                          jmp_en;
    logic [ADDR_W-1:0]             jmp_addr;
    logic [ADDR_W-1:0]             pc_out;
    logic                          halted;
    logic                          fetch_busy;

    modport master (
        input  start, rom_data, exec_done, jmp_en, jmp_addr,
        output rom_rd, rom_addr, opcode, operand, ir_valid, pc_out, halted, fetch_busy
    );

    modport slave (
        output start, rom_data, exec_done, jmp_en, jmp_addr,
        input  rom_rd, rom_addr, opcode, operand, ir_valid, pc_out, halted, fetch_busy
    );
endinterface

// File: rtl/instr_fetch_seq_pc_counter.sv
// pc_counter: program counter with load (priority) and increment, wrapping mod 2^ADDR_W.
//   clk, rst (async active-low), inc, load, load_val -> pc
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetches 16-bit instructions as two ROM byte reads (high, then low),
// holds them for execution and advances or jumps the PC on exec_done.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : instr_fetch_seq_if.master (ROM port, instruction outputs, exec handshake, status)
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int                  ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [OPCODE_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_seq_if.master  bus
);
    state_t               state;
    logic [INSTR_W-1:0]   ir;
    logic                 ir_valid_q;
    logic                 halted_q;
    logic [ADDR_W-1:0]    pc;
    logic                 pc_inc;
    logic                 pc_load;

    // PC steps past each byte as it is captured; a jump only lands on a completed instruction.
    assign pc_inc  = (state == FHC) || (state == FLC);
    assign pc_load = (state == EXEC) && bus.exec_done && bus.jmp_en;

    pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (bus.jmp_addr),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            ir         <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) state <= FH;
                FH:   state <= FHC;
                FHC: begin
                    ir[15:8] <= bus.rom_data;
                    state    <= FL;
                end
                FL:   state <= FLC;
                FLC: begin
                    ir[7:0] <= bus.rom_data;
                    // Opcode lives entirely in the high byte, already captured.
                    if (ir[15:12] == HALT_OP) begin
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end else begin
                        ir_valid_q <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: if (bus.exec_done) begin
                    ir_valid_q <= 1'b0;
                    state      <= FH;
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end

    assign bus.rom_rd     = (state == FH) || (state == FL);
    assign bus.rom_addr   = pc;
    assign bus.pc_out     = pc;
    assign bus.opcode     = ir[15:12];
    assign bus.operand    = ir[11:0];
    assign bus.ir_valid   = ir_valid_q;
    assign bus.halted     = halted_q;
    assign bus.fetch_busy = (state == FH) || (state == FHC) || (state == FL) || (state == FLC);
endmodule
